digit_scan_mux: RTL and testbench

//  Parametrised, time-multiplexed successor to the combinational N:1 nibble selector.

---
 rtl/digit_scan_pkg.sv | 35 +++
 rtl/digit_scan_mux_prescaler.sv | 45 ++++
 rtl/digit_scan_mux.sv | 119 +++++++++++
 tb/tb_digit_scan_mux.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared constants and helpers for the digit scan multiplexer.
package digit_scan_pkg;

    localparam logic AN_OFF = 1'b1;
    localparam logic AN_ON  = 1'b0;

    // Upper bound on channel count supported by the search helper
    localparam int unsigned MAX_CH    = 32;
    localparam int unsigned MAX_SEL_W = 5;

    // Select-index width for n channels (at least one bit)
    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Round-robin search: next set bit of mask above cur, wrapping at num; cur if none
    function automatic int unsigned next_enabled(input logic [MAX_CH-1:0] mask,
                                                 input int unsigned       cur,
                                                 input int unsigned       num);
        int unsigned idx;
        int unsigned result;
        logic        found;
        result = cur;
        found  = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = (cur + i) % num;
            if ((i <= num) && !found && mask[idx[MAX_SEL_W-1:0]]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// Slot timer: counts 0..SCAN_DIV-1 while enabled, flags terminal count and blank window.
module scan_prescaler #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic cnt_tc,
    output logic blank
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_tc_q, cnt_tc_d;
    logic             blank_q, blank_d;

    // Next count; flags are registered versions of the comparisons on the current count
    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != CNT_W'(SCAN_DIV - 1))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        cnt_tc_d = (cnt_d == CNT_W'(SCAN_DIV - 1));
        blank_d  = (cnt_d < CNT_W'(BLANK_CYC));
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cnt_tc_q <= 1'b0;
            blank_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            cnt_tc_q <= cnt_tc_d;
            blank_q  <= blank_d;
        end
    end

    assign cnt_tc = cnt_tc_q;
    assign blank  = blank_q;

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner with skip mask, anti-ghost blanking and frame snapshot.
// Optional leading-zero blanking is built when DIGIT_SCAN_LZB_EN is defined.
module digit_scan_mux
    import digit_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 8,
    parameter  int unsigned DATA_W    = 4,
    parameter  int unsigned SCAN_DIV  = 100000,
    parameter  int unsigned BLANK_CYC = 1000,
    localparam int unsigned SEL_W     = sel_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [DATA_W-1:0]        data_out,
    output logic [NUM_CH-1:0]        an_n,
    output logic [SEL_W-1:0]         sel,
    output logic                     frame_start
);

    logic                     cnt_tc;
    logic                     blank;
    logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [DATA_W-1:0]        data_out_q, data_out_d;
    logic [NUM_CH-1:0]        an_n_q, an_n_d;
    logic                     frame_start_q, frame_start_d;
    logic                     run_q, run_d;
    logic [DATA_W-1:0]        word_c [NUM_CH];
    logic [NUM_CH-1:0]        lzb_blank_c;
    logic [MAX_CH-1:0]        mask_c;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .cnt_tc (cnt_tc),
        .blank  (blank)
    );

    // Snapshot split into per-channel words
    for (genvar k = 0; k < NUM_CH; k++) begin : g_word
        assign word_c[k] = snap_q[k*DATA_W +: DATA_W];
    end

    assign mask_c = MAX_CH'(ch_en);

`ifdef DIGIT_SCAN_LZB_EN
    logic zero_run;

    // Blank channel k>0 when it and every more significant snapshot word are zero
    always_comb begin
        lzb_blank_c = '0;
        zero_run    = 1'b1;
        for (int k = int'(NUM_CH) - 1; k > 0; k--) begin
            zero_run       = zero_run & (word_c[k] == '0);
            lzb_blank_c[k] = zero_run;
        end
    end
`else
    assign lzb_blank_c = '0;
`endif

    // Channel advance, frame snapshot and registered output values
    always_comb begin
        sel_d         = sel_q;
        snap_d        = snap_q;
        data_out_d    = data_out_q;
        an_n_d        = {NUM_CH{AN_OFF}};
        frame_start_d = 1'b0;
        run_d         = en;
        if (en) begin
            data_out_d = word_c[sel_q];
            if (!run_q) begin
                snap_d        = data_in;
                frame_start_d = 1'b1;
            end else if (cnt_tc && (ch_en != '0)) begin
                sel_d = SEL_W'(next_enabled(mask_c, 32'(sel_q), NUM_CH));
                if (sel_d <= sel_q) begin
                    snap_d        = data_in;
                    frame_start_d = 1'b1;
                end
            end
            if (ch_en[sel_q] && !blank && !lzb_blank_c[sel_q]) begin
                an_n_d[sel_q] = AN_ON;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q        <= '0;
            sel_q         <= '0;
            data_out_q    <= '0;
            an_n_q        <= {NUM_CH{AN_OFF}};
            frame_start_q <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            snap_q        <= snap_d;
            sel_q         <= sel_d;
            data_out_q    <= data_out_d;
            an_n_q        <= an_n_d;
            frame_start_q <= frame_start_d;
            run_q         <= run_d;
        end
    end

    assign data_out    = data_out_q;
    assign an_n        = an_n_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux (4 channels, 8-cycle slots, 2 blank cycles).
module tb_digit_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  ch_en;
    logic [3:0]  data_out;
    logic [3:0]  an_n;
    logic [1:0]  sel;
    logic        frame_start;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int fs_cnt  = 0;
    int bad_c   = 0;
    int lzb_bad = 0;
    logic mon_c = 1'b0;

    digit_scan_mux #(
        .NUM_CH    (4),
        .DATA_W    (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .data_in     (data_in),
        .ch_en       (ch_en),
        .data_out    (data_out),
        .an_n        (an_n),
        .sel         (sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance n falling edges, accumulating monitors after each
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            fs_cnt += int'(frame_start);
            if (mon_c && (an_n == 4'b1101 || an_n == 4'b0111)) bad_c++;
            if (an_n[3] == 1'b0 || an_n[2] == 1'b0) lzb_bad++;
        end
    endtask

    task automatic goto(input int n);
        step(n - cyc);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ch_en = 4'h0; data_in = 16'h0;
        step(3);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);

        // Normal scan of all four channels
        rst_n = 1'b1; en = 1'b1; ch_en = 4'hF; data_in = 16'h4321;
        cyc = 0; fs_cnt = 0;
        goto(1);
        chk("a_fs_first", 32'(frame_start), 32'h1);
        chk("a_sel0", 32'(sel), 32'h0);
        goto(2);
        chk("a_fs_pulse_end", 32'(frame_start), 32'h0);
        chk("a_dout0", 32'(data_out), 32'h1);
        chk("a_blank0", 32'(an_n), 32'hF);
        goto(3);
        chk("a_an0", 32'(an_n), 32'hE);
        goto(8);
        chk("a_an0_last", 32'(an_n), 32'hE);
        chk("a_sel1", 32'(sel), 32'h1);
        goto(9);
        chk("a_blank1", 32'(an_n), 32'hF);
        chk("a_dout1", 32'(data_out), 32'h2);
        goto(11);
        chk("a_an1", 32'(an_n), 32'hD);
        goto(17);
        chk("a_sel2", 32'(sel), 32'h2);
        chk("a_dout2", 32'(data_out), 32'h3);
        chk("a_blank2", 32'(an_n), 32'hF);
        goto(19);
        chk("a_an2", 32'(an_n), 32'hB);
        goto(25);
        chk("a_sel3", 32'(sel), 32'h3);
        chk("a_dout3", 32'(data_out), 32'h4);
        goto(27);
        chk("a_an3", 32'(an_n), 32'h7);
        goto(31);
        chk("a_fs_count", 32'(fs_cnt), 32'h1);
        goto(32);
        chk("a_wrap_sel", 32'(sel), 32'h0);
        chk("a_wrap_fs", 32'(frame_start), 32'h1);
        goto(33);
        chk("a_wrap_fs_end", 32'(frame_start), 32'h0);
        chk("a_wrap_dout", 32'(data_out), 32'h1);

        // New data mid-frame stays hidden until the next frame
        data_in = 16'h8765;
        goto(43);
        chk("b_old_digit", 32'(data_out), 32'h2);
        goto(64);
        chk("b_new_frame_fs", 32'(frame_start), 32'h1);
        goto(66);
        chk("b_new_dout0", 32'(data_out), 32'h5);
        goto(74);
        chk("b_new_dout1", 32'(data_out), 32'h6);

        // Skip mask: only channels 0 and 2
        ch_en = 4'b0101; mon_c = 1'b1;
        goto(80);
        chk("c_sel2", 32'(sel), 32'h2);
        goto(88);
        chk("c_sel0", 32'(sel), 32'h0);
        chk("c_wrap_fs", 32'(frame_start), 32'h1);
        goto(90);
        chk("c_dout0", 32'(data_out), 32'h5);
        goto(96);
        chk("c_sel2_again", 32'(sel), 32'h2);
        goto(98);
        chk("c_dout2", 32'(data_out), 32'h7);
        goto(99);
        chk("c_an2", 32'(an_n), 32'hB);
        mon_c = 1'b0;
        chk("c_no_skipped_anode", 32'(bad_c), 32'h0);

        // Clear the active channel mid-slot, then single channel, then empty mask
        ch_en = 4'b0001;
        goto(100);
        chk("d_clear_mid_slot", 32'(an_n), 32'hF);
        goto(104);
        chk("d_sel_single", 32'(sel), 32'h0);
        goto(112);
        chk("d_single_fs", 32'(frame_start), 32'h1);
        ch_en = 4'b0100;
        goto(120);
        chk("d_sel_to2", 32'(sel), 32'h2);
        chk("d_no_wrap_fs", 32'(frame_start), 32'h0);
        goto(121);
        ch_en = 4'h0;
        goto(130);
        chk("d_empty_sel_held", 32'(sel), 32'h2);
        chk("d_empty_an_off", 32'(an_n), 32'hF);

        // Pause with en low for 20 cycles mid-slot
        ch_en = 4'hF;
        goto(139);
        chk("e_sel3", 32'(sel), 32'h3);
        chk("e_an3_on", 32'(an_n), 32'h7);
        en = 1'b0;
        goto(159);
        chk("e_paused_an", 32'(an_n), 32'hF);
        chk("e_paused_sel", 32'(sel), 32'h3);
        chk("e_paused_dout", 32'(data_out), 32'h8);
        en = 1'b1;
        goto(160);
        chk("e_resume_fs", 32'(frame_start), 32'h1);
        chk("e_resume_sel", 32'(sel), 32'h3);
        goto(161);
        chk("e_resume_blank", 32'(an_n), 32'hF);
        goto(162);
        chk("e_resume_an", 32'(an_n), 32'h7);
        goto(166);
        chk("e_full_slot", 32'(sel), 32'h3);
        goto(167);
        chk("e_next_sel", 32'(sel), 32'h0);

        // Asynchronous reset between clock edges
        goto(178);
        chk("f_pre_sel", 32'(sel), 32'h1);
        chk("f_pre_an", 32'(an_n), 32'hD);
        chk("f_pre_dout", 32'(data_out), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("f_async_dout", 32'(data_out), 32'h0);
        chk("f_async_an", 32'(an_n), 32'hF);
        chk("f_async_sel", 32'(sel), 32'h0);
        chk("f_async_fs", 32'(frame_start), 32'h0);
        step(2);
        rst_n = 1'b1; cyc = 0;
        goto(1);
        chk("f_restart_fs", 32'(frame_start), 32'h1);
        chk("f_restart_sel", 32'(sel), 32'h0);
        goto(2);
        chk("f_restart_dout", 32'(data_out), 32'h5);
        goto(8);
        chk("f_restart_sel1", 32'(sel), 32'h1);

`ifdef DIGIT_SCAN_LZB_EN
        // Leading-zero blanking with digits 0,0,5,0 (msd first)
        rst_n = 1'b0; data_in = 16'h0050; ch_en = 4'hF; en = 1'b1;
        step(2);
        rst_n = 1'b1; cyc = 0; lzb_bad = 0;
        goto(3);
        chk("lzb_an0", 32'(an_n), 32'hE);
        goto(11);
        chk("lzb_an1", 32'(an_n), 32'hD);
        chk("lzb_dout1", 32'(data_out), 32'h5);
        goto(19);
        chk("lzb_an2_off", 32'(an_n), 32'hF);
        goto(27);
        chk("lzb_an3_off", 32'(an_n), 32'hF);
        goto(33);
        chk("lzb_upper_never_on", 32'(lzb_bad), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
